// File: rtl/io_keysw_dev.sv
// Memory-mapped KEY/SW input device: synchronized keys, debounced switches.
// Define IO_KEYSW_IRQ_EN to add the registered irq output.
module io_keysw_dev #(
    parameter int               DBITS           = 32,
    parameter int               KEYBITS         = 4,
    parameter int               SWBITS          = 10,
    parameter logic [DBITS-1:0] ADDRKDATA       = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hFFFFF084,
    parameter logic [DBITS-1:0] ADDRSDATA       = 32'hFFFFF090,
    parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hFFFFF094,
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   addr,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [DBITS-1:0]   wdata,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    output logic [DBITS-1:0]   rdata,
    output logic               hit
`ifdef IO_KEYSW_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [KEYBITS-1:0] ksync1, ksync, kdata;
    logic [SWBITS-1:0]  ssync1, ssync, sprev, sdata;
    logic [CW-1:0]      cnt;
    logic               krdy, kovr, kie;
    logic               srdy, sovr, sie;

    logic sel_kd, sel_kc, sel_sd, sel_sc;
    logic rd_act, kd_rd, sd_rd, kc_wr, sc_wr;
    logic kchg, sstable, ssat, supd;
    logic unused_wdata;

    assign sel_kd = (addr == ADDRKDATA);
    assign sel_kc = (addr == ADDRKCTRL);
    assign sel_sd = (addr == ADDRSDATA);
    assign sel_sc = (addr == ADDRSCTRL);

    // A simultaneous store wins: no read side effect
    assign rd_act = rd_en & ~wr_en;
    assign kd_rd  = rd_act & sel_kd;
    assign sd_rd  = rd_act & sel_sd;
    assign kc_wr  = wr_en & sel_kc;
    assign sc_wr  = wr_en & sel_sc;

    assign kchg    = (ksync != kdata);
    assign sstable = (ssync == sprev);
    assign ssat    = (cnt == CMAX);
    // Require a stable sample too, so a saturated counter never passes a fresh edge
    assign supd    = sstable & ssat & (ssync != sdata);

    assign unused_wdata = ^{wdata[DBITS-1:9], wdata[7:3], wdata[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ksync1 <= '0;
            ksync  <= '0;
            ssync1 <= '0;
            ssync  <= '0;
            sprev  <= '0;
        end else begin
            ksync1 <= ~KEY;
            ksync  <= ksync1;
            ssync1 <= SW;
            ssync  <= ssync1;
            sprev  <= ssync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kdata <= '0;
            krdy  <= 1'b0;
            kovr  <= 1'b0;
            kie   <= 1'b0;
        end else begin
            if (kchg) begin
                kdata <= ksync;
                krdy  <= 1'b1;
            end else if (kd_rd) begin
                krdy  <= 1'b0;
            end
            if (kchg && krdy && !kd_rd) begin
                kovr <= 1'b1;
            end else if (kc_wr) begin
                kovr <= kovr & wdata[2];
            end
            if (kc_wr) begin
                kie <= wdata[8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!sstable) begin
            cnt <= '0;
        end else if (!ssat) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sdata <= '0;
            srdy  <= 1'b0;
            sovr  <= 1'b0;
            sie   <= 1'b0;
        end else begin
            if (supd) begin
                sdata <= ssync;
                srdy  <= 1'b1;
            end else if (sd_rd) begin
                srdy  <= 1'b0;
            end
            if (supd && srdy && !sd_rd) begin
                sovr <= 1'b1;
            end else if (sc_wr) begin
                sovr <= sovr & wdata[2];
            end
            if (sc_wr) begin
                sie <= wdata[8];
            end
        end
    end

    assign hit = rd_en & (sel_kd | sel_kc | sel_sd | sel_sc);

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                ADDRKDATA: rdata = DBITS'(kdata);
                ADDRKCTRL: rdata = DBITS'({kie, 5'b0, kovr, 1'b0, krdy});
                ADDRSDATA: rdata = DBITS'(sdata);
                ADDRSCTRL: rdata = DBITS'({sie, 5'b0, sovr, 1'b0, srdy});
                default:   rdata = '0;
            endcase
        end
    end

`ifdef IO_KEYSW_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (krdy & kie) | (srdy & sie);
        end
    end
`endif

endmodule

// File: tb/tb_io_keysw_dev.sv
// Directed self-checking bench for io_keysw_dev with an 8-cycle debounce.
module tb_io_keysw_dev;

    localparam logic [31:0] AKD = 32'hFFFFF080;
    localparam logic [31:0] AKC = 32'hFFFFF084;
    localparam logic [31:0] ASD = 32'hFFFFF090;
    localparam logic [31:0] ASC = 32'hFFFFF094;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] rdata;
    logic        hit;
`ifdef IO_KEYSW_IRQ_EN
    logic        irq;
`endif

    int checks   = 0;
    int failures = 0;

    io_keysw_dev #(.DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .wdata (wdata),
        .KEY   (KEY),
        .SW    (SW),
        .rdata (rdata),
        .hit   (hit)
`ifdef IO_KEYSW_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Combinational look with no clock edge, so no side effect
    task automatic peek(input string tag, input logic [31:0] a,
                        input logic [31:0] exp, input logic exp_hit);
        addr  = a;
        rd_en = 1'b1;
        #1;
        chk({tag, "_data"}, rdata, exp);
        chk({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
        rd_en = 1'b0;
        addr  = '0;
    endtask

    // Load held across one edge, so the read side effect takes place
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        #1;
        chk(tag, rdata, exp);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        wdata = '0;
        addr  = '0;
    endtask

    initial begin
        reset = 1'b1;
        addr  = '0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        wdata = '0;
        KEY   = 4'hF;
        SW    = '0;
        tick(3);

        // Reset state
        addr = AKD;
        #1;
        chk("rst_idle_rdata", rdata, 32'h0);
        chk("rst_idle_hit", {31'b0, hit}, 32'h0);
        peek("rst_kctrl", AKC, 32'h0, 1'b1);
        peek("rst_sctrl", ASC, 32'h0, 1'b1);

        // 1: key sync latency and read clearing ready
        reset = 1'b0;
        KEY   = 4'b1110;
        tick(2);
        peek("klat2", AKD, 32'h0, 1'b1);
        tick(1);
        peek("klat3", AKD, 32'h1, 1'b1);
        peek("klat3_ctrl", AKC, 32'h1, 1'b1);
        tick(2);
        rd("kd_read", AKD, 32'h1);
        peek("kctrl_clr", AKC, 32'h0, 1'b1);

        // 2: two key changes without a read set overrun
        KEY = 4'b1101;
        tick(4);
        KEY = 4'b1011;
        tick(4);
        peek("kd_ovr", AKD, 32'h4, 1'b1);
        peek("kc_ovr", AKC, 32'h5, 1'b1);
        wr(AKC, 32'h0);
        peek("kc_wr0", AKC, 32'h1, 1'b1);

        // 3: switch debounce
        SW = 10'h155;
        tick(20);
        peek("sd_stable", ASD, 32'h155, 1'b1);
        peek("sc_stable", ASC, 32'h1, 1'b1);
        rd("sd_read", ASD, 32'h155);
        peek("sc_clr", ASC, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 10'h2AA : 10'h155;
            tick(5);
        end
        peek("sd_bounce", ASD, 32'h155, 1'b1);
        peek("sc_bounce", ASC, 32'h0, 1'b1);
        SW = 10'h3FF;
        tick(10);
        peek("sd_edge10", ASD, 32'h155, 1'b1);
        tick(1);
        peek("sd_edge11", ASD, 32'h3FF, 1'b1);
        peek("sc_edge11", ASC, 32'h1, 1'b1);
        rd("sd_read2", ASD, 32'h3FF);

        // 4: key change on the same edge as a KDATA read
        rd("kd_pre", AKD, 32'h4);
        KEY = 4'b0111;
        tick(2);
        rd("kd_coll_old", AKD, 32'h4);
        peek("kd_coll", AKD, 32'h8, 1'b1);
        peek("kc_coll", AKC, 32'h1, 1'b1);

        // 5: data writes ignored, rd+wr is a write, unmapped address
        wr(AKD, 32'hFFFF);
        peek("kd_ro", AKD, 32'h8, 1'b1);
        addr  = AKD;
        rd_en = 1'b1;
        wr_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        wr_en = 1'b0;
        peek("kc_rdwr", AKC, 32'h1, 1'b1);
        peek("unmapped", 32'hFFFFF08C, 32'h0, 1'b0);

        // Overrun survives a write of 1, clears on 0; IE read back
        KEY = 4'b1111;
        tick(4);
        wr(AKC, 32'h104);
        peek("kc_keep", AKC, 32'h105, 1'b1);
        wr(AKC, 32'h000);
        peek("kc_clr2", AKC, 32'h1, 1'b1);

        // 6: interrupt path
        rd("kd_pre6", AKD, 32'h0);
        wr(AKC, 32'h100);
        tick(2);
`ifdef IO_KEYSW_IRQ_EN
        chk("irq_idle", {31'b0, irq}, 32'h0);
`endif
        KEY = 4'b1110;
        tick(3);
        peek("kc_irqrdy", AKC, 32'h101, 1'b1);
`ifdef IO_KEYSW_IRQ_EN
        chk("irq_lag", {31'b0, irq}, 32'h0);
`endif
        tick(1);
`ifdef IO_KEYSW_IRQ_EN
        chk("irq_set", {31'b0, irq}, 32'h1);
`endif
        rd("kd_irq", AKD, 32'h1);
        tick(1);
`ifdef IO_KEYSW_IRQ_EN
        chk("irq_clr", {31'b0, irq}, 32'h0);
`endif

        // Reset mid-debounce, then debounce restarts
        SW = 10'h0F0;
        tick(5);
        reset = 1'b1;
        #1;
        peek("sd_rst", ASD, 32'h0, 1'b1);
        peek("kc_rst", AKC, 32'h0, 1'b1);
`ifdef IO_KEYSW_IRQ_EN
        chk("irq_rst", {31'b0, irq}, 32'h0);
`endif
        tick(2);
        reset = 1'b0;
        tick(10);
        peek("sd_restart10", ASD, 32'h0, 1'b1);
        tick(1);
        peek("sd_restart11", ASD, 32'h0F0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_keysw_dev.md
Name: io_keysw_dev

Overview:
Memory-mapped KEY/SW input device sitting directly downstream of the pipeline MEM stage. It consumes the MEM-stage address, read-enable and write-enable, and returns read data for the KEY/SW register window. It replaces the raw `~KEY` read path with four registers:
- Synchronized key data.
- Debounced switch data.
- Ready/overrun status bits for each.
The MEM stage muxes `rdata` into its load value whenever `hit` is 1.

Parameters:
DBITS, 32, data/address width
KEYBITS, 4, number of push keys
SWBITS, 10, number of slide switches
ADDRKDATA, 32'hFFFFF080, key data register address
ADDRKCTRL, 32'hFFFFF084, key control/status register address
ADDRSDATA, 32'hFFFFF090, switch data register address
ADDRSCTRL, 32'hFFFFF094, switch control/status register address
DEBOUNCE_CYCLES, 100000, number of consecutive stable cycles required before SDATA updates (minimum 2)

Ports:
clk  in  1  system clock (PLL output)
reset  in  1  asynchronous, active-high
addr  in  DBITS  MEM-stage memory address
rd_en  in  1  MEM-stage load in progress
wr_en  in  1  MEM-stage store in progress
wdata  in  DBITS  store data
KEY  in  KEYBITS  raw keys, active-low, asynchronous
SW  in  SWBITS  raw switches, asynchronous
rdata  out  DBITS  read data, combinational from addr and rd_en
hit  out  1  rd_en high and addr matches one of the 4 registers

Behaviour:
Reset:
- KDATA=0, key ready=0, key overrun=0, key IE=0.
- SDATA=0, sw ready=0, sw overrun=0, sw IE=0.
- Sync flops = 0, debounce counter = 0.
- rdata=0 and hit=0 while rd_en=0.

Input sync:
- KEY is inverted, then passed through a 2-flop synchronizer → ksync.
- SW passes through a 2-flop synchronizer → ssync.

Key path:
- When ksync != KDATA: KDATA <= ksync, key ready <= 1.
- If key ready was already 1 and there is no KDATA read this cycle: key overrun <= 1.
- Net latency from a KEY edge to KDATA update: 3 clk edges.

Switch path:
- Counter resets to 0 whenever ssync differs from the previous ssync sample; otherwise it increments, saturating at DEBOUNCE_CYCLES-1.
- When the counter equals DEBOUNCE_CYCLES-1 and ssync != SDATA: SDATA <= ssync, sw ready <= 1.
- Overrun rule is identical to the key path.
- A bouncing input never updates SDATA.

Read map (32-bit, zero-extended):
- KDATA: KEYBITS data.
- KCTRL: bit0 ready, bit2 overrun, bit8 IE.
- SDATA: SWBITS data.
- SCTRL: same bit layout as KCTRL.
- Unmapped address: rdata=0, hit=0.

Read side effects:
- On the clk edge with rd_en and addr==ADDRKDATA: key ready <= 0.
- Same for SDATA and sw ready.
- Reading a CTRL register has no side effect.

Writes:
- DATA registers are read-only; writes are ignored.
- CTRL write: overrun <= overrun & wdata[2] (software clears by writing 0); IE <= wdata[8]; the ready bit is not writable.

Simultaneous events:
- New data on the same edge as a DATA read: data updates and ready stays 1 (set wins over clear); overrun is unchanged.
- Overrun set on the same edge as a CTRL write-0: set wins.
- rd_en and wr_en both high: treat as a write only, with no read side effect.

Reset mid-operation clears all state immediately. The debounce restarts after reset deassertion.

Optional Feature:
- Macro: `IO_KEYSW_IRQ_EN`.
- When defined: adds output port `irq` (1 bit), registered: irq <= (key ready & key IE) | (sw ready & sw IE). Reset value is 0; irq asserts 1 cycle after the condition holds.
- When not defined: no `irq` port; the IE bits still read and write as described.

Test Plan:
1. DEBOUNCE_CYCLES=8. Release reset, KEY=4'b1110, read ADDRKDATA at cycle 5 → rdata=32'h1, hit=1. Then read ADDRKCTRL → 32'h0 (ready cleared by the previous read).
2. KEY changes to 4'b1101, then to 4'b1011 without any read → KDATA=32'h4, KCTRL=32'h5. Write KCTRL wdata=0 → KCTRL=32'h1.
3. SW=10'h155 held 20 cycles → SDATA=32'h155, SCTRL=32'h1. SW toggling every 5 cycles for 50 cycles → SDATA stays 32'h155, no ready set.
4. Key change lands on the same edge as a KDATA read → KDATA holds the new value, KCTRL=32'h1 (ready kept, overrun 0).
5. Write wdata=32'hFFFF to ADDRKDATA → KDATA unchanged. Read ADDRSW-1 (32'hFFFFF08C) → rdata=0, hit=0.
6. `IO_KEYSW_IRQ_EN` defined: write KCTRL=32'h100, press key → irq=1 one cycle after ready sets; read KDATA → irq=0 on the following cycle. Assert reset mid-debounce → SDATA=0, irq=0.
